// File: rtl/lcd_fetch_pkg.sv
// Shared types and geometry for the LCD line fetcher: FSM state encoding,
// default panel geometry and the frame size helper.
package lcd_fetch_pkg;

  typedef enum logic [2:0] {
    F_IDLE      = 3'd0,
    F_REQ       = 3'd1,
    F_WAIT_DATA = 3'd2,
    F_WAIT_FREE = 3'd3,
    F_DONE      = 3'd4
  } fetch_state_e;

  localparam int DEF_LINE_WORDS = 480;
  localparam int DEF_LINES      = 272;

  function automatic int FRAME_WORDS(input int line_words, input int lines);
    return line_words * lines;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO for fetched pixels; flush empties it and takes
// priority over a push or pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en_s, rd_en_s;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH_W);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en_s = push & ~full & ~flush;
  assign rd_en_s = pop & ~empty & ~flush;

  // Pointer update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else         wr_ptr_d = wr_ptr_q;
      if (rd_en_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
      else         rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sdram_line_fetcher.sv
// Streams one frame of pixels from SDRAM into a show-ahead FIFO, one read at
// a time. Define SDRAM_FETCH_STATS_EN to enable the saturating underflow_count.
module sdram_line_fetcher
  import lcd_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LINES      = DEF_LINES,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_enable,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          rd_ready,
  input  logic                          busy,
  output logic [DATA_WIDTH-1:0]         pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          underflow,
  output logic [15:0]                   underflow_count
);

  localparam int TOTAL = FRAME_WORDS(LINE_WORDS, LINES);
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         TOTAL_W = CW'(TOTAL);
  localparam logic [LW-1:0]         DEPTH_W = LW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_W  = ADDR_WIDTH'(BASE_ADDR);

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CW-1:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    rd_enable_q, rd_enable_d;
  logic                    frame_done_q, frame_done_d;
  logic                    underflow_q, underflow_d;
  logic                    restart_pend_q, restart_pend_d;
  logic                    restart_s, push_s, pop_s, uf_cond_s;
  logic                    empty_s, full_s;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (push_s & ~full_s),
    .din   (rd_data),
    .pop   (pop_s),
    .dout  (pix_data),
    .empty (empty_s),
    .full  (full_s),
    .level (fifo_level)
  );

  assign pop_s     = pix_ready & ~empty_s;
  assign uf_cond_s = pix_ready & empty_s & ~frame_done_q;

  // Next-state and request logic; a restart overrides everything else.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    word_d         = word_q;
    rd_addr_d      = rd_addr_q;
    rd_enable_d    = rd_enable_q;
    frame_done_d   = frame_done_q;
    restart_pend_d = restart_pend_q;
    underflow_d    = underflow_q | uf_cond_s;
    restart_s      = 1'b0;
    push_s         = 1'b0;
    case (state_q)
      F_DONE: begin
        if (frame_start) restart_s = 1'b1;
        else             state_d   = F_DONE;
      end
      F_IDLE: begin
        if (frame_start || restart_pend_q) begin
          restart_s = 1'b1;
        end else if (word_q == TOTAL_W) begin
          state_d      = F_DONE;
          frame_done_d = 1'b1;
        end else if (fifo_level < DEPTH_W) begin
          state_d     = F_REQ;
          rd_enable_d = 1'b1;
          rd_addr_d   = addr_q;
        end else begin
          state_d = F_IDLE;
        end
      end
      F_REQ: begin
        if (frame_start) restart_pend_d = 1'b1;
        else             restart_pend_d = restart_pend_q;
        // Busy seen high is the controller accepting the request.
        if (busy) begin
          rd_enable_d = 1'b0;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          word_d      = word_q + CW'(1);
          state_d     = F_WAIT_DATA;
        end else begin
          state_d = F_REQ;
        end
      end
      F_WAIT_DATA: begin
        if (frame_start) restart_pend_d = 1'b1;
        else             restart_pend_d = restart_pend_q;
        if (rd_ready) begin
          push_s  = ~restart_pend_q & ~frame_start;
          state_d = F_WAIT_FREE;
        end else begin
          state_d = F_WAIT_DATA;
        end
      end
      F_WAIT_FREE: begin
        if (frame_start) restart_pend_d = 1'b1;
        else             restart_pend_d = restart_pend_q;
        if (!busy) state_d = F_IDLE;
        else       state_d = F_WAIT_FREE;
      end
      default: begin
        state_d     = F_DONE;
        rd_enable_d = 1'b0;
      end
    endcase
    if (restart_s) begin
      state_d        = F_IDLE;
      addr_d         = BASE_W;
      word_d         = '0;
      rd_enable_d    = 1'b0;
      frame_done_d   = 1'b0;
      underflow_d    = 1'b0;
      restart_pend_d = 1'b0;
    end else begin
      restart_pend_d = restart_pend_d;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= F_DONE;
      addr_q         <= BASE_W;
      word_q         <= '0;
      rd_addr_q      <= '0;
      rd_enable_q    <= 1'b0;
      frame_done_q   <= 1'b1;
      underflow_q    <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      word_q         <= word_d;
      rd_addr_q      <= rd_addr_d;
      rd_enable_q    <= rd_enable_d;
      frame_done_q   <= frame_done_d;
      underflow_q    <= underflow_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_enable  = rd_enable_q;
  assign pix_valid  = ~empty_s;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;

`ifdef SDRAM_FETCH_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating count of underflow cycles.
  always_comb begin
    ucnt_d = ucnt_q;
    if (restart_s)                              ucnt_d = 16'd0;
    else if (uf_cond_s && ucnt_q != 16'hFFFF)   ucnt_d = ucnt_q + 16'd1;
    else                                        ucnt_d = ucnt_q;
  end

  // Underflow counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= 16'd0;
    else        ucnt_q <= ucnt_d;
  end

  assign underflow_count = ucnt_q;
`else
  assign underflow_count = 16'd0;
`endif

endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Directed + randomized bench for sdram_line_fetcher with a latency-5 SDRAM
// responder (memory[a] = a) and a queue-based expected pixel/address stream.
module tb_sdram_line_fetcher;

  localparam int LWORDS = 4;
  localparam int NLINES = 2;
  localparam int NWORDS = LWORDS * NLINES;
  localparam int DEPTH  = 4;
  localparam int LAT    = 5;
`ifdef SDRAM_FETCH_STATS_EN
  localparam int UF_EXP = 3;
`else
  localparam int UF_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [23:0] rd_addr;
  logic        rd_enable;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic        busy;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [2:0]  fifo_level;
  logic        frame_done;
  logic        underflow;
  logic [15:0] underflow_count;

  int total = 0;
  int bad   = 0;
  int issued[$];
  int popped[$];
  int defer_cnt  = 0;
  bit rand_defer = 1'b0;
  bit ok;

  sdram_line_fetcher #(
    .ADDR_WIDTH(24), .DATA_WIDTH(16), .LINE_WORDS(LWORDS), .LINES(NLINES),
    .BASE_ADDR(0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .rd_addr(rd_addr),
    .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .fifo_level(fifo_level), .frame_done(frame_done), .underflow(underflow),
    .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // Controller model: accepts after optional deferral, returns data LAT cycles later.
  initial begin : responder
    int          phase;
    int          lat;
    logic [23:0] cur;
    phase = 0; lat = 0; cur = '0;
    busy = 1'b0; rd_ready = 1'b0; rd_data = 16'd0;
    forever begin
      @(negedge clk);
      rd_ready = 1'b0;
      if (!rst_n) begin
        busy = 1'b0; phase = 0; defer_cnt = 0;
      end else begin
        case (phase)
          0: if (rd_enable) begin
               if (defer_cnt > 0) defer_cnt--;
               else begin
                 busy = 1'b1; cur = rd_addr; issued.push_back(int'(rd_addr));
                 lat = LAT; phase = 1;
                 if (rand_defer) defer_cnt = int'($urandom_range(0, 3));
               end
             end
          1: begin
               lat--;
               if (lat == 0) begin rd_ready = 1'b1; rd_data = cur[15:0]; phase = 2; end
             end
          default: begin busy = 1'b0; phase = 0; end
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input int q[$], input int first, input int n);
    chk({tag, "_len"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < q.size() && i < n; i++) chk(tag, 32'(q[i]), 32'(first + i));
  endtask

  // Advance to the next falling edge, logging a pop that the coming rising edge performs.
  task automatic tick();
    if (pix_valid && pix_ready && !frame_start) popped.push_back(int'(pix_data));
    @(negedge clk);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input bit random_ready);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (random_ready) pix_ready = 1'($urandom_range(0, 1));
      tick();
      if (frame_done && !pix_valid) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
    repeat (3) tick();
    chk("rst_rd_enable", 32'(rd_enable), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd1);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_uf_count", 32'(underflow_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic fetch with a free-running consumer.
    issued.delete(); popped.delete();
    pix_ready = 1'b1;
    pulse_start();
    chk("start_en_t1", 32'(rd_enable), 32'd0);
    chk("start_done_clr", 32'(frame_done), 32'd0);
    tick();
    chk("start_en_t2", 32'(rd_enable), 32'd1);
    chk("start_addr_t2", 32'(rd_addr), 32'd0);
    run_to_done("basic_done", 1'b0);
    chk_seq("basic_addr", issued, 0, NWORDS);
    chk_seq("basic_pix", popped, 0, NWORDS);
    chk("basic_underflow", 32'(underflow), 32'd1);
    repeat (20) tick();
    chk("basic_no_extra", 32'(issued.size()), 32'(NWORDS));
    chk("basic_en_low", 32'(rd_enable), 32'd0);

    // Backpressure: FIFO fills and fetching stops, then resumes at address 4.
    issued.delete(); popped.delete();
    pix_ready = 1'b0;
    pulse_start();
    repeat (60) tick();
    chk("bp_reads", 32'(issued.size()), 32'd4);
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_en_low", 32'(rd_enable), 32'd0);
    chk("bp_head", 32'(pix_data), 32'd0);
    chk("bp_no_underflow", 32'(underflow), 32'd0);
    pix_ready = 1'b1;
    run_to_done("bp_done", 1'b0);
    chk_seq("bp_addr", issued, 0, NWORDS);
    chk_seq("bp_pix", popped, 0, NWORDS);

    // Refresh deferral: request held stable until accepted.
    issued.delete(); popped.delete();
    pix_ready = 1'b0;
    defer_cnt = 10;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_enable) begin ok = 1'b1; break; end
    end
    chk("ref_req_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("ref_hold_en", 32'(rd_enable), 32'd1);
      chk("ref_hold_addr", 32'(rd_addr), 32'd0);
    end
    chk("ref_not_yet", 32'(issued.size()), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (issued.size() == 1) begin ok = 1'b1; break; end
      tick();
    end
    chk("ref_accepted", 32'(ok), 32'd1);
    defer_cnt = 1000;
    repeat (15) tick();
    chk("ref_single_read", 32'(issued.size()), 32'd1);
    chk("ref_level", 32'(fifo_level), 32'd1);
    chk("ref_head", 32'(pix_data), 32'd0);
    chk("ref_next_en", 32'(rd_enable), 32'd1);
    chk("ref_next_addr", 32'(rd_addr), 32'd1);

    // Async reset while a request is pending.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(rd_enable), 32'd0);
    chk("arst_addr", 32'(rd_addr), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_done", 32'(frame_done), 32'd1);
    chk("arst_uf", 32'(underflow), 32'd0);
    chk("arst_ufc", 32'(underflow_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Mid-frame restart while word 2 is in flight.
    issued.delete(); popped.delete();
    defer_cnt = 0;
    pix_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (issued.size() == 3) begin ok = 1'b1; break; end
      tick();
    end
    chk("mid_reach_w2", 32'(ok), 32'd1);
    tick();
    chk("mid_level_pre", 32'(fifo_level), 32'd2);
    pulse_start();
    chk("mid_flushed", 32'(fifo_level), 32'd0);
    chk("mid_issued", 32'(issued.size()), 32'd3);
    issued.delete(); popped.delete();
    pix_ready = 1'b1;
    run_to_done("mid_done", 1'b0);
    chk_seq("mid_addr", issued, 0, NWORDS);
    chk_seq("mid_pix", popped, 0, NWORDS);

    // Underflow: drain a full FIFO while the controller stalls.
    issued.delete(); popped.delete();
    pix_ready = 1'b0;
    pulse_start();
    chk("uf_clr_flag", 32'(underflow), 32'd0);
    chk("uf_clr_count", 32'(underflow_count), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (fifo_level == 3'd4) begin ok = 1'b1; break; end
      tick();
    end
    chk("uf_filled", 32'(ok), 32'd1);
    defer_cnt = 1000;
    chk("uf_none_yet", 32'(underflow), 32'd0);
    pix_ready = 1'b1;
    repeat (7) tick();
    pix_ready = 1'b0;
    tick();
    chk_seq("uf_pix", popped, 0, 4);
    chk("uf_valid", 32'(pix_valid), 32'd0);
    chk("uf_flag", 32'(underflow), 32'd1);
    chk("uf_count", 32'(underflow_count), 32'(UF_EXP));
    defer_cnt = 0;
    pulse_start();
    chk("uf_restart_flush", 32'(fifo_level), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (fifo_level == 3'd4) begin ok = 1'b1; break; end
      tick();
    end
    chk("uf_refill", 32'(ok), 32'd1);
    chk("uf_discard_head", 32'(pix_data), 32'd0);
    chk("uf_flag_cleared", 32'(underflow), 32'd0);
    chk("uf_count_cleared", 32'(underflow_count), 32'd0);
    pix_ready = 1'b1;
    run_to_done("uf_drain", 1'b0);

    // Randomized consumer and refresh deferrals over several frames.
    rand_defer = 1'b1;
    for (int f = 0; f < 3; f++) begin
      issued.delete(); popped.delete();
      pix_ready = 1'b0;
      pulse_start();
      run_to_done("rnd_done", 1'b1);
      chk_seq("rnd_addr", issued, 0, NWORDS);
      chk_seq("rnd_pix", popped, 0, NWORDS);
    end
    rand_defer = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_line_fetcher.md
# sdram_line_fetcher

Read-only host-side client of the SDRAM controller's host interface. It streams a frame of 16-bit pixels from SDRAM into a small FIFO for the LCD scan-out path. Each frame is a linear sequence of single-word reads starting at `BASE_ADDR`. It sits between the LCD timing generator, which supplies `frame_start` and consumes pixels, and the SDRAM controller.

## Interface
Parameters:
- `ADDR_WIDTH`, 24: host address width (bank+row+col).
- `DATA_WIDTH`, 16: pixel/word width.
- `LINE_WORDS`, 480: words per line.
- `LINES`, 272: lines per frame.
- `BASE_ADDR`, 0: word address of the first pixel.
- `FIFO_DEPTH`, 16: pixel FIFO entries; power of two, ≥2.

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- `clk`  in  1  system clock, shared with the SDRAM controller.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_start`  in  1  one-cycle pulse; (re)starts a frame fetch.
- `rd_addr`  out  ADDR_WIDTH  read address to the controller; registered.
- `rd_enable`  out  1  read request to the controller; registered.
- `rd_data`  in  DATA_WIDTH  read data from the controller.
- `rd_ready`  in  1  one-cycle strobe; `rd_data` is valid in the same cycle.
- `busy`  in  1  controller busy; high while a read/write is in progress.
- `pix_data`  out  DATA_WIDTH  FIFO head (show-ahead).
- `pix_valid`  out  1  FIFO non-empty.
- `pix_ready`  in  1  consumer pops when `pix_valid & pix_ready`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `frame_done`  out  1  high once all `LINE_WORDS*LINES` words are issued; cleared by `frame_start`.
- `underflow`  out  1  sticky; set when `pix_ready` is high with the FIFO empty while a frame is active (`frame_done` low).
- `underflow_count`  out  16  see Configuration.

## Operation
FSM states: `F_IDLE`, `F_REQ`, `F_WAIT_DATA`, `F_WAIT_FREE`, `F_DONE`.

- **Reset.** State is `F_DONE`. `rd_enable`=0, `rd_addr`=0, FIFO empty, `pix_valid`=0, `fifo_level`=0, `frame_done`=1, `underflow`=0, `underflow_count`=0.
- **`frame_start`, no read in flight.** FIFO flushed, address counter set to `BASE_ADDR`, word counter set to 0, `underflow` and `frame_done` cleared, next state `F_IDLE`.
- **`F_IDLE`.**
  - If word counter = `LINE_WORDS*LINES`: go to `F_DONE` and set `frame_done`.
  - Else if `fifo_level` < `FIFO_DEPTH`: go to `F_REQ`, drive `rd_enable`=1 and `rd_addr`=current address.
- **`F_REQ`.** Hold `rd_enable` and `rd_addr` constant until `busy` is sampled high; that sample is acceptance.
  - Next cycle: `rd_enable`=0, address+1, word counter+1, state `F_WAIT_DATA`.
  - A refresh occurring before acceptance is tolerated: the request stays asserted.
- **`F_WAIT_DATA`.** On `rd_ready`, push `rd_data` into the FIFO, then go to `F_WAIT_FREE`.
- **`F_WAIT_FREE`.** Wait for `busy` low, then go to `F_IDLE`.
- **Outstanding reads.** At most one. The issue rule (`fifo_level` < depth, no other writer) guarantees a push never hits a full FIFO.
- **Address width.** The address counter is `ADDR_WIDTH` bits and wraps modulo 2^`ADDR_WIDTH`.
- **`frame_start` while in `F_REQ`, `F_WAIT_DATA` or `F_WAIT_FREE`.**
  - Latch `restart_pend`. The FIFO is flushed immediately.
  - The in-flight transaction completes normally, but its `rd_data` is discarded (not pushed).
  - On reaching `F_IDLE`, apply the restart (counters, flags).
  - A second `frame_start` while pending is absorbed.
- **Simultaneous push and pop.** Allowed; `fifo_level` is unchanged.
- **`frame_start` coincident with a pop.** Flush wins.

## Timing
- `frame_start` at cycle t, in `F_DONE` or `F_IDLE`: `rd_enable` rises at t+2 (t+1 restart applied, t+2 request registered).
- Request accepted at cycle a (`busy` sampled 1): `rd_enable` low at a+1.
- Pixel push: `rd_ready` at cycle r gives `pix_valid` high at r+1 (FIFO was empty).
- Next request no earlier than the first cycle after `busy` is sampled low.
- `underflow` sets in the cycle after the offending sample.

## Configuration
- `SDRAM_FETCH_STATS_EN` defined: `underflow_count` is a 16-bit saturating counter.
  - Increments once per cycle in which the underflow condition holds.
  - Cleared by reset and on restart.
- Undefined: `underflow_count` is tied to 0 and no counter logic exists. The sticky `underflow` flag is always present.

## Structure
- Shared package `lcd_fetch_pkg`:
  - FSM state enum.
  - Default geometry constants (480, 272).
  - `FRAME_WORDS` helper function.
- Sub-module `fetch_fifo`: synchronous, show-ahead FIFO of depth `FIFO_DEPTH`.
  - Ports: `clk`, `rst_n`, `flush`, `push`, `din`, `pop`, `dout`, `empty`, `full`, `level`.
  - The fetcher instantiates it once.

## Test plan
Test parameters: `LINE_WORDS`=4, `LINES`=2, `FIFO_DEPTH`=4; responder model of the controller, read latency 5, memory[a]=a.
- **Basic fetch.** Reset, then `frame_start` → reads of addresses 0..7 issued in order; `pix_data` sequence 0..7 (with `pix_ready`=1); `frame_done`=1 after the 8th issue; no further `rd_enable`.
- **Backpressure.** `pix_ready`=0 → exactly 4 reads complete and `fifo_level`=4, no 5th `rd_enable`. Raising `pix_ready` resumes fetching at address 4.
- **Refresh deferral.** Model holds `busy` low for 10 cycles after `rd_enable` (refresh) → `rd_enable` and `rd_addr`=0 held stable throughout; a single read results.
- **Mid-frame restart.** `frame_start` while in `F_WAIT_DATA` for address 2 → word 2 is discarded, FIFO empty; the next request is address 0 and the output restarts at 0.
- **Underflow.** `pix_ready`=1 with the FIFO empty for 3 cycles mid-frame → `underflow`=1; `underflow_count`=3 with `SDRAM_FETCH_STATS_EN`, 0 without; both clear on `frame_start`.
- **Async reset.** `rst_n` asserted in `F_REQ` → `rd_enable`=0 immediately; all outputs at reset values.
